gf180mcu_fd_sc_mcu7t5v0__invpipe: RTL and testbench

- Parametrised, clocked successor to the single-bit inverter cell: WIDTH-bit data path, DEPTH register stages, per-beat invert/pass mode.
- Valid/ready handshake with full-throughput backpressure and an occupancy count.
- Behavioural model for the 7-track 5V library, used where an inverting bus must be retimed across DEPTH cycles.
- Carries VDD/VSS pins like every other cell in the library.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__invpipe_pkg.sv | 25 ++
 rtl/gf180mcu_fd_sc_mcu7t5v0__invpipe_stage.sv | 25 ++
 rtl/gf180mcu_fd_sc_mcu7t5v0__invpipe.sv | 114 +++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__invpipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invpipe_pkg.sv
// Shared types and constants for the retimed inverting bus pipe.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gf180mcu_fd_sc_mcu7t5v0__invpipe_pkg;

   // Legal parameter ranges of the pipe.
   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 64;
   localparam int DEPTH_MIN = 1;
   localparam int DEPTH_MAX = 8;

   // Width of the occupancy counter: it must hold 0..depth inclusive.
   function automatic int OCC_W(input int depth);
      return $clog2(depth + 1);
   endfunction

   // One pipeline stage. Data is sized for the widest legal bus; narrower
   // instances zero-extend, so the unused upper bits are constant zero.
   typedef struct packed {
      logic                 vld;
      logic                 inv;
      logic [WIDTH_MAX-1:0] data;
   } stage_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invpipe_stage.sv
// One register stage of the inverting pipe: holds valid, mode bit and data.
// Latency: 1 cycle from load to output.
// Backpressure: holds its contents whenever load is low.
module gf180mcu_fd_sc_mcu7t5v0__invpipe_stage
   import gf180mcu_fd_sc_mcu7t5v0__invpipe_pkg::*;
#(
   parameter logic INV_RST = 1'b1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  stage_t nxt,
   output stage_t cur
);

   // Synchronous reset empties the stage; otherwise load from upstream when advancing.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur <= '{vld: 1'b0, inv: INV_RST, data: '0};
      end else if (load) begin
         cur <= nxt;
      end
   end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invpipe.sv
// Clocked WIDTH-bit inverter: per-beat invert/pass, retimed over DEPTH stages.
// Latency: DEPTH cycles with ZN_RDY held high; 1 beat/cycle throughput.
// Backpressure: valid/ready, bubbles collapse; I_RDY = ZN_RDY | pipe not full.
// Optional ZN_PAR output (XOR of ZN) when GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN is defined.
module gf180mcu_fd_sc_mcu7t5v0__invpipe
   import gf180mcu_fd_sc_mcu7t5v0__invpipe_pkg::*;
#(
   parameter int   WIDTH   = 8,
   parameter int   DEPTH   = 2,
   parameter logic INV_RST = 1'b1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [WIDTH-1:0]           I,
   input  logic                       INV,
   input  logic                       I_VLD,
   output logic                       I_RDY,
   output logic [WIDTH-1:0]           ZN,
   output logic                       ZN_VLD,
   input  logic                       ZN_RDY,
   output logic [OCC_W(DEPTH)-1:0]    OCC,
`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
   output logic                       ZN_PAR,
`endif
   inout  wire                        VDD,
   inout  wire                        VSS
);

   localparam int OW = OCC_W(DEPTH);

   stage_t             stg [DEPTH];
   stage_t             nxt [DEPTH];
   stage_t             entry;
   logic [DEPTH-1:0]   vld;
   logic [DEPTH-1:0]   adv;
   logic               accept;
   logic               emit;
   logic [OW-1:0]      occ_q;

   // A stage may load when it or anything between it and the output has a
   // hole, or when the output is being drained. Written in closed form so the
   // ready chain has no combinational self-reference.
   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      assign vld[k] = stg[k].vld;
      assign adv[k] = ZN_RDY | ~(&vld[DEPTH-1:k]);

      if (k == 0) begin : g_head
         assign nxt[k] = entry;
      end else begin : g_body
         assign nxt[k] = stg[k-1];
      end

      gf180mcu_fd_sc_mcu7t5v0__invpipe_stage #(
         .INV_RST (INV_RST)
      ) u_stage (
         .clk  (CLK),
         .rst  (RST),
         .load (adv[k]),
         .nxt  (nxt[k]),
         .cur  (stg[k])
      );
   end

   // Inversion happens once, at entry; later stages only move the beat along.
   always_comb begin
      entry      = '0;
      entry.vld  = I_VLD & adv[0];
      entry.inv  = INV;
      entry.data = WIDTH_MAX'(I ^ {WIDTH{INV}});
   end

   assign I_RDY  = adv[0];
   assign ZN_VLD = vld[DEPTH-1];
   assign ZN     = stg[DEPTH-1].data[WIDTH-1:0];

   assign accept = I_VLD & adv[0];
   assign emit   = vld[DEPTH-1] & ZN_RDY;

   // Occupancy tracks accepts minus emits; the handshake keeps it in 0..DEPTH.
   always_ff @(posedge CLK) begin
      if (RST) begin
         occ_q <= '0;
      end else begin
         unique case ({accept, emit})
            2'b10:   occ_q <= occ_q + OW'(1);
            2'b01:   occ_q <= occ_q - OW'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign OCC = occ_q;

`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
   logic par_nxt;

   // Upper data bits are always zero, so reducing the full field is exact.
   assign par_nxt = ^nxt[DEPTH-1].data;

   // Parity is registered alongside the output stage so it moves in lockstep with ZN.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ZN_PAR <= 1'b0;
      end else if (adv[DEPTH-1]) begin
         ZN_PAR <= par_nxt;
      end
   end
`endif

   // Power pins and the carried mode bit have no logic function at the output.
   logic unused_bits;
   assign unused_bits = ^{VDD, VSS, stg[DEPTH-1].inv, stg[DEPTH-1].data};

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__invpipe.sv
// Self-checking bench for the inverting pipe: directed scenarios plus random traffic.
// Reference: a queue of in-flight beats with their stage position.
// Outputs are sampled at the falling edge, inputs changed there too.
module tb_gf180mcu_fd_sc_mcu7t5v0__invpipe;

   localparam int WIDTH = 8;
   localparam int DEPTH = 2;
   localparam int OW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] i;
   logic             inv;
   logic             i_vld;
   logic             i_rdy;
   logic [WIDTH-1:0] zn;
   logic             zn_vld;
   logic             zn_rdy;
   logic [OW-1:0]    occ;
`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
   logic             zn_par;
`endif
   wire              vdd = 1'b1;
   wire              vss = 1'b0;

   gf180mcu_fd_sc_mcu7t5v0__invpipe #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .INV_RST (1'b1)
   ) dut (
      .CLK    (clk),
      .RST    (rst),
      .I      (i),
      .INV    (inv),
      .I_VLD  (i_vld),
      .I_RDY  (i_rdy),
      .ZN     (zn),
      .ZN_VLD (zn_vld),
      .ZN_RDY (zn_rdy),
      .OCC    (occ),
`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
      .ZN_PAR (zn_par),
`endif
      .VDD    (vdd),
      .VSS    (vss)
   );

   always #5 clk = ~clk;

   // Reference model: beats in flight, oldest first, with their stage index.
   typedef struct {
      logic [WIDTH-1:0] data;
      int               pos;
   } mbeat_t;

   mbeat_t mq[$];
   int     n_chk  = 0;
   int     n_fail = 0;
   bit     last_acc = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output against the model, then advance the model and the clock.
   task automatic step();
      bit evld;
      bit erdy;
      int ahead;
      #1;
      evld = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
      erdy = (mq.size() < DEPTH) || zn_rdy;
      check("zn_vld", 64'(zn_vld), 64'(evld));
      check("occ", 64'(occ), 64'(mq.size()));
      check("i_rdy", 64'(i_rdy), 64'(erdy));
      if (evld) begin
         check("zn", 64'(zn), 64'(mq[0].data));
`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
         check("zn_par", 64'(zn_par), 64'(^mq[0].data));
`endif
      end
      if (rst) begin
         mq.delete();
         last_acc = 1'b0;
      end else begin
         if (evld && zn_rdy) void'(mq.pop_front());
         ahead = DEPTH;
         foreach (mq[j]) begin
            if (mq[j].pos < DEPTH - 1 && mq[j].pos + 1 != ahead)
               mq[j].pos = mq[j].pos + 1;
            ahead = mq[j].pos;
         end
         last_acc = i_vld && erdy;
         if (last_acc) mq.push_back('{data: i ^ {WIDTH{inv}}, pos: 0});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      i_vld  = 1'b0;
      zn_rdy = 1'b1;
      for (int n = 0; n < DEPTH + 1; n++) step();
   endtask

   task automatic put(input logic [WIDTH-1:0] d, input logic m);
      i     = d;
      inv   = m;
      i_vld = 1'b1;
   endtask

   initial begin
      logic [3:0]       bub_v;
      logic [WIDTH-1:0] bub_d [4];
      int               vp;
      int               rp;

      rst = 1'b1; i = '0; inv = 1'b0; i_vld = 1'b0; zn_rdy = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_zn_vld", 64'(zn_vld), 64'(0));
      check("rst_occ", 64'(occ), 64'(0));
      check("rst_zn", 64'(zn), 64'(0));
      check("rst_i_rdy", 64'(i_rdy), 64'(1));
`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
      check("rst_zn_par", 64'(zn_par), 64'(0));
`endif

      // Streaming: inverted then passed beat, back to back.
      zn_rdy = 1'b1;
      put(8'h3C, 1'b1); step();
      put(8'h3C, 1'b0); step();
      i_vld = 1'b0;
      check("stream_vld0", 64'(zn_vld), 64'(1));
      check("stream_zn0", 64'(zn), 64'(8'hC3));
      step();
      check("stream_vld1", 64'(zn_vld), 64'(1));
      check("stream_zn1", 64'(zn), 64'(8'h3C));
      drain();

      // Backpressure: two beats fill the pipe, the third is refused.
      zn_rdy = 1'b0;
      put(8'h11, 1'b0); step();
      put(8'h22, 1'b1); step();
      put(8'h33, 1'b0);
      #1;
      check("bp_i_rdy", 64'(i_rdy), 64'(0));
      check("bp_occ", 64'(occ), 64'(2));
      check("bp_zn", 64'(zn), 64'(8'h11));
      step();
      check("bp_hold_zn", 64'(zn), 64'(8'h11));
      i_vld = 1'b0; zn_rdy = 1'b1;
      check("bp_occ2", 64'(occ), 64'(2));
      step();
      check("bp_occ1", 64'(occ), 64'(1));
      check("bp_zn2", 64'(zn), 64'(8'hDD));
      step();
      check("bp_occ0", 64'(occ), 64'(0));
      drain();

      // Simultaneous accept and emit on a full pipe.
      zn_rdy = 1'b0;
      put(8'h40, 1'b0); step();
      put(8'h41, 1'b0); step();
      zn_rdy = 1'b1;
      for (int n = 0; n < 10; n++) begin
         put(WIDTH'(8'h50 + n), n[0]);
         #1;
         check("full_i_rdy", 64'(i_rdy), 64'(1));
         check("full_occ", 64'(occ), 64'(2));
         step();
      end
      drain();

      // Bubbles: valid pattern 1,0,1,0 reappears one stage-time later.
      bub_v = 4'b0101;
      bub_d[0] = 8'hA5; bub_d[1] = 8'h00; bub_d[2] = 8'h5A; bub_d[3] = 8'h00;
      zn_rdy = 1'b1;
      for (int n = 0; n < 6; n++) begin
         if (n < 4) put(bub_d[n], 1'b0);
         else i_vld = 1'b0;
         if (n < 4) i_vld = bub_v[n];
         step();
         if (n >= 1 && n <= 4) begin
            check("bub_vld", 64'(zn_vld), 64'(bub_v[n-1]));
            if (bub_v[n-1]) check("bub_zn", 64'(zn), 64'(bub_d[n-1]));
         end
      end
      drain();

`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
      // Parity of the output beat.
      zn_rdy = 1'b1;
      put(8'h01, 1'b1); step();
      put(8'h03, 1'b0); step();
      i_vld = 1'b0;
      check("par_zn0", 64'(zn), 64'(8'hFE));
      check("par_p0", 64'(zn_par), 64'(1));
      step();
      check("par_zn1", 64'(zn), 64'(8'h03));
      check("par_p1", 64'(zn_par), 64'(0));
      drain();
`endif

      // Reset mid-stream with two beats in flight.
      zn_rdy = 1'b0;
      put(8'h77, 1'b0); step();
      put(8'h88, 1'b1); step();
      i_vld = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      check("mid_rst_vld", 64'(zn_vld), 64'(0));
      check("mid_rst_occ", 64'(occ), 64'(0));
      check("mid_rst_i_rdy", 64'(i_rdy), 64'(1));
      zn_rdy = 1'b1;
      for (int n = 0; n < DEPTH + 2; n++) begin
         step();
         check("mid_rst_no_stale", 64'(zn_vld), 64'(0));
      end

      // Random traffic in blocks of differing input and output pressure.
      for (int c = 0; c < 4000; c++) begin
         if (c % 500 == 0) begin
            vp = $urandom_range(20, 100);
            rp = $urandom_range(10, 100);
         end
         if (!(i_vld && !last_acc)) begin
            i_vld = ($urandom_range(0, 99) < vp);
            i     = WIDTH'($urandom);
            inv   = 1'($urandom);
         end
         zn_rdy = ($urandom_range(0, 99) < rp);
         rst    = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
